// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary converters.
package bcd_pkg;

  localparam int DIGITS     = 4;
  localparam int BCD_W      = 16;
  localparam int BIN_W      = 14;
  localparam int CONV_STEPS = 14;
  localparam int CNT_W      = 4;
  localparam int MAX_DEC    = 9999;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True when every nibble of a packed BCD word is a legal decimal digit.
  function automatic logic digits_valid(input logic [BCD_W-1:0] bcd);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: a digit that reached 8 or more
// after the right shift held a carried-in half-ten, so take 3 back off.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to binary converter, one bit per clock (reverse
// double dabble). start/busy/done handshake, one conversion in flight.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int BITS = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      bcd_1000,
  input  logic [3:0]      bcd_100,
  input  logic [3:0]      bcd_10,
  input  logic [3:0]      bcd_1,
  output logic [BITS-1:0] value,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            overflow
);

  // Smallest result that no longer fits in BITS.
  localparam logic [BIN_W:0] LIMIT = (BIN_W+1)'(1) << BITS;

  state_e            state_q, state_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITS-1:0]   value_q, value_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              overflow_q, overflow_d;

  logic [BCD_W-1:0]  req_bcd;
  logic [BCD_W-1:0]  bcd_shift;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BIN_W-1:0]  bin_next;
  logic              bin_ovf;
  logic              last_step;

  assign req_bcd   = {bcd_1000, bcd_100, bcd_10, bcd_1};

  // One right shift of the combined {bcd, bin} register.
  assign bcd_shift = bcd_q >> 1;
  assign bin_next  = {bcd_q[0], bin_q[BIN_W-1:1]};
  assign bin_ovf   = {1'b0, bin_next} >= LIMIT;
  assign last_step = (cnt_q == CNT_W'(CONV_STEPS - 1));

  // Correct each shifted digit in the same cycle as the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (bcd_shift[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    value_d    = value_q;
    done_d     = 1'b0;
    error_d    = error_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (digits_valid(req_bcd)) begin
            state_d    = ST_SHIFT;
            bcd_d      = req_bcd;
            bin_d      = '0;
            cnt_d      = '0;
            error_d    = 1'b0;
            overflow_d = 1'b0;
          end else begin
            // Rejected request still completes, so the requester sees done.
            error_d    = 1'b1;
            overflow_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_next;
        if (last_step) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          value_d    = bin_next[BITS-1:0];
          overflow_d = bin_ovf;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      value_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      done_q     <= done_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  assign value    = value_q;
  assign busy     = (state_q == ST_SHIFT);
  assign done     = done_q;
  assign error    = error_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a 14-bit and a 12-bit instance share stimulus.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  d3, d2, d1, d0;
  logic [13:0] value;
  logic        busy, done, error, overflow;
  logic [11:0] v12;
  logic        busy12, done12, err12, ovf12;

  int n_assert = 0;
  int n_fail   = 0;
  int lat, bcnt, dn;

  always #5 clk = ~clk;

  bcd_to_bin #(.BITS(14)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bcd_1000(d3), .bcd_100(d2), .bcd_10(d1), .bcd_1(d0),
    .value(value), .busy(busy), .done(done), .error(error), .overflow(overflow)
  );

  bcd_to_bin #(.BITS(12)) dut12 (
    .clk(clk), .rst(rst), .start(start),
    .bcd_1000(d3), .bcd_100(d2), .bcd_10(d1), .bcd_1(d0),
    .value(v12), .busy(busy12), .done(done12), .error(err12), .overflow(ovf12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue a start in the current cycle and wait (bounded) for done.
  // lat = edges after the accepting edge until done is seen; bcnt = busy cycles.
  task automatic conv(input int a, input int b, input int c, input int e);
    d3 = 4'(a); d2 = 4'(b); d1 = 4'(c); d0 = 4'(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic conv_n(input int n);
    conv(n / 1000, (n / 100) % 10, (n / 10) % 10, n % 10);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    d3 = '0; d2 = '0; d1 = '0; d0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1234: latency and busy length
    conv(1, 2, 3, 4);
    chk("1234_latency", 32'(lat), 32'd14);
    chk("1234_busy_cycles", 32'(bcnt), 32'd14);
    chk("1234_value", 32'(value), 32'd1234);
    chk("1234_error", 32'(error), 32'd0);
    chk("1234_overflow", 32'(overflow), 32'd0);
    chk("1234_value12", 32'(v12), 32'd1234);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("value_held", 32'(value), 32'd1234);

    // 9999 max, 12-bit wraps and overflows
    conv(9, 9, 9, 9);
    chk("9999_value", 32'(value), 32'd9999);
    chk("9999_overflow", 32'(overflow), 32'd0);
    chk("9999_value12", 32'(v12), 32'd1807);
    chk("9999_overflow12", 32'(ovf12), 32'd1);

    // 0000 back-to-back in the done cycle
    conv(0, 0, 0, 0);
    chk("0000_latency", 32'(lat), 32'd14);
    chk("0000_value", 32'(value), 32'd0);
    chk("0000_overflow12", 32'(ovf12), 32'd0);

    // Illegal digit: immediate done, error, value kept
    conv(1, 2, 3, 4);
    conv(0, 10, 0, 0);
    chk("err_latency", 32'(lat), 32'd0);
    chk("err_error", 32'(error), 32'd1);
    chk("err_value_kept", 32'(value), 32'd1234);
    chk("err_overflow", 32'(overflow), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_error12", 32'(err12), 32'd1);
    @(posedge clk); #1;
    chk("err_held", 32'(error), 32'd1);
    chk("err_done_pulse", 32'(done), 32'd0);
    chk("err_busy_after", 32'(busy), 32'd0);

    // Valid request clears error; 4095 fits 12 bits
    conv(4, 0, 9, 5);
    chk("4095_error_cleared", 32'(error), 32'd0);
    chk("4095_value", 32'(value), 32'd4095);
    chk("4095_value12", 32'(v12), 32'd4095);
    chk("4095_overflow12", 32'(ovf12), 32'd0);

    // start during SHIFT is ignored
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1;
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("busy_start_latency", 32'(lat), 32'd14);
    chk("busy_start_value", 32'(value), 32'd1234);
    @(posedge clk); #1;
    chk("busy_start_no_restart", 32'(busy), 32'd0);

    // Async reset at shift 7 aborts without done
    d3 = 4'd5; d2 = 4'd6; d1 = 4'd7; d0 = 4'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_value", 32'(value), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_value12", 32'(v12), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    conv(0, 0, 4, 2);
    chk("post_abort_latency", 32'(lat), 32'd14);
    chk("post_abort_value", 32'(value), 32'd42);

    // Strided back-to-back sweep over the decimal range
    for (int n = 0; n <= 9999; n += 37) begin
      conv_n(n);
      chk("sweep_latency", 32'(lat), 32'd14);
      chk("sweep_value", 32'(value), 32'(n));
      chk("sweep_value12", 32'(v12), 32'(n % 4096));
      chk("sweep_overflow12", 32'(ovf12), (n >= 4096) ? 32'd1 : 32'd0);
    end
    conv_n(9999);
    chk("sweep_last_value", 32'(value), 32'd9999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
